micro_sequencer: RTL and testbench

- Microprogram sequencer for the core control unit.
- Owns the micro-program counter (uPC), which it presents to the combinational microcode ROM, and computes the next address from the ROM's BT, condition and jump_addr fields, the IR opcode and the ALU zero flag.
- Adds start/done handshake, memory-wait stalls, halt detection, out-of-range fault detection and a cycle counter.
- Sits between the instruction register/ALU flags and the microcode ROM, one per core.

---
 rtl/micro_sequencer.sv | 176 +++++++++++++++++
 tb/tb_micro_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer for the core control unit.
// Owns the micro-program counter (uPC) that addresses the combinational
// microcode ROM. It computes the next address from the ROM's BT, condition
// and jump_addr fields, the IR opcode and the ALU zero flag. It also handles
// the start/done handshake, memory-wait stalls, halt detection, out-of-range
// fault detection and a saturating cycle counter.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse, begins execution at FETCH_ADDR
//   BT           ROM branch-to-target bit (dispatch on opcode[6:0])
//   condition    ROM branch condition field
//   jump_addr    ROM next-address field
//   opcode       IR opcode; opcode[7]=1 always faults on dispatch
//   z_flag       ALU zero flag
//   mem_ready    memory handshake completion
//   reg_out      uPC, zero-extended to 16 bits, drives the ROM address
//   busy         high in RUN or WAIT
//   done         high in HALT
//   error        high in FAULT
//   cycle_count  clocks spent in RUN plus WAIT since the last start
module micro_sequencer #(
  parameter int unsigned ROM_DEPTH  = 86,
  parameter int unsigned FETCH_ADDR = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             BT,
  input  logic [1:0]       condition,
  input  logic [6:0]       jump_addr,
  input  logic [7:0]       opcode,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic [15:0]      reg_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [7:0] DEPTH_LIM = 8'(ROM_DEPTH);
  localparam logic [6:0] FETCH_PC  = 7'(FETCH_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_HALT,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       upc_q, upc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  // Candidate next addresses are 8 bits wide so that opcode[7] and the
  // increment past 127 both land in the out-of-range comparison.
  logic [7:0] seq_addr;
  logic [7:0] target;
  logic       load;

  assign seq_addr = {1'b0, upc_q} + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    cnt_d   = cnt_q;
    target  = '0;
    load    = 1'b0;

    if ((state_q == S_RUN || state_q == S_WAIT) && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          upc_d   = FETCH_PC;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (BT) begin
          target = opcode;
          load   = 1'b1;
        end else begin
          case (condition)
            2'b00: begin
              // An unconditional jump to itself is the halt idiom.
              if (jump_addr == upc_q) begin
                state_d = S_HALT;
              end else begin
                target = {1'b0, jump_addr};
                load   = 1'b1;
              end
            end
            2'b01: begin
              target = z_flag ? {1'b0, jump_addr} : seq_addr;
              load   = 1'b1;
            end
            2'b10: begin
              target = z_flag ? seq_addr : {1'b0, jump_addr};
              load   = 1'b1;
            end
            default: begin
              if (mem_ready) begin
                target = {1'b0, jump_addr};
                load   = 1'b1;
              end else begin
                state_d = S_WAIT;
              end
            end
          endcase
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          target = {1'b0, jump_addr};
          load   = 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
        upc_d   = '0;
      end
    endcase

    if (load) begin
      if (target >= DEPTH_LIM) begin
        state_d = S_FAULT;
        upc_d   = '0;
      end else begin
        state_d = S_RUN;
        upc_d   = target[6:0];
      end
    end

    busy_d  = (state_d == S_RUN) || (state_d == S_WAIT);
    done_d  = (state_d == S_HALT);
    error_d = (state_d == S_FAULT);
  end

  assign reg_out     = {9'b0, upc_q};
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a ROM array feeds the DUT combinationally from
// reg_out. A behavioural model steps once per clock from its own uPC, and the
// DUT outputs are compared with that model on every falling edge. Directed
// literal checks pin the model at key points of each scenario.
module tb_micro_sequencer;

  localparam int ROM_DEPTH = 86;
  localparam int FETCH     = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  opcode;
  logic        z_flag;
  logic        mem_ready;
  logic [15:0] reg_out;
  logic        busy, done, error;
  logic [31:0] cycle_count;

  // ROM word layout: {BT, condition[1:0], jump_addr[6:0]}
  logic [9:0] rom [0:127];
  logic [9:0] rom_word;
  assign rom_word = rom[reg_out[6:0]];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  micro_sequencer #(
    .ROM_DEPTH (86),
    .FETCH_ADDR(1),
    .CNT_W     (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .BT         (rom_word[9]),
    .condition  (rom_word[8:7]),
    .jump_addr  (rom_word[6:0]),
    .opcode     (opcode),
    .z_flag     (z_flag),
    .mem_ready  (mem_ready),
    .reg_out    (reg_out),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cycle_count(cycle_count)
  );

  typedef enum logic [2:0] {M_IDLE, M_RUN, M_WAIT, M_HALT, M_FAULT} mmode_t;
  typedef struct packed {
    mmode_t      mode;
    logic [6:0]  pc;
    logic [31:0] cnt;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t s, input logic st,
                                   input logic [7:0] op, input logic z,
                                   input logic mr);
    mstate_t    n;
    logic [9:0] w;
    int         jmp;
    int         tgt;
    n   = s;
    w   = rom[s.pc];
    jmp = int'(w[6:0]);
    tgt = -1;
    if (s.mode == M_RUN || s.mode == M_WAIT) begin
      if (s.cnt != 32'hFFFF_FFFF) n.cnt = s.cnt + 32'd1;
    end
    case (s.mode)
      M_IDLE, M_HALT: begin
        if (st) begin
          n.mode = M_RUN;
          n.pc   = 7'(FETCH);
          n.cnt  = 32'd0;
        end
      end
      M_RUN: begin
        if (w[9]) begin
          tgt = int'(op);
        end else if (w[8:7] == 2'd0) begin
          if (jmp == int'(s.pc)) n.mode = M_HALT;
          else tgt = jmp;
        end else if (w[8:7] == 2'd1) begin
          tgt = z ? jmp : int'(s.pc) + 1;
        end else if (w[8:7] == 2'd2) begin
          tgt = z ? int'(s.pc) + 1 : jmp;
        end else begin
          if (mr) tgt = jmp;
          else n.mode = M_WAIT;
        end
      end
      M_WAIT: begin
        if (mr) tgt = jmp;
      end
      default: ;
    endcase
    if (tgt >= ROM_DEPTH) begin
      n.mode = M_FAULT;
      n.pc   = 7'd0;
    end else if (tgt >= 0) begin
      n.mode = M_RUN;
      n.pc   = 7'(tgt);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{M_IDLE, 7'd0, 32'd0};
    else     m <= step(m, start, opcode, z_flag, mem_ready);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model reg_out", 32'(reg_out), {25'b0, m.pc});
    check("model busy", 32'(busy), 32'(m.mode == M_RUN || m.mode == M_WAIT));
    check("model done", 32'(done), 32'(m.mode == M_HALT));
    check("model error", 32'(error), 32'(m.mode == M_FAULT));
    check("model cycle_count", cycle_count, m.cnt);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    opcode    = 8'h08;
    z_flag    = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = {1'b0, 2'b00, 7'(i)};
    rom[1]  = {1'b0, 2'b00, 7'd2};
    rom[2]  = {1'b0, 2'b00, 7'd3};
    rom[3]  = {1'b1, 2'b00, 7'd0};
    rom[8]  = {1'b0, 2'b00, 7'd60};
    rom[60] = {1'b0, 2'b01, 7'd62};
    rom[62] = {1'b0, 2'b00, 7'd40};
    rom[40] = {1'b0, 2'b11, 7'd41};
    rom[41] = {1'b0, 2'b00, 7'd80};
    tick(2);
    rst = 1'b0;
    tick(1);

    // reset mid-run, then idle
    pulse_start;
    tick(2);
    check("midrun reg_out", 32'(reg_out), 32'd3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle reg_out", 32'(reg_out), 32'd0);
      check("idle flags", {29'b0, busy, done, error}, 32'd0);
      check("idle cycle_count", cycle_count, 32'd0);
    end

    // dispatch, conditional, memory wait, halt
    pulse_start;
    check("start reg_out", 32'(reg_out), 32'd1);
    check("start busy", 32'(busy), 32'd1);
    tick(3);
    check("dispatch reg_out", 32'(reg_out), 32'd8);
    check("dispatch cycle_count", cycle_count, 32'd3);
    tick(2);
    check("cond z=1 reg_out", 32'(reg_out), 32'd62);
    tick(1);
    check("wait entry reg_out", 32'(reg_out), 32'd40);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("wait hold reg_out", 32'(reg_out), 32'd40);
    check("wait cycle_count", cycle_count, 32'd9);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    check("wait release reg_out", 32'(reg_out), 32'd41);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("halt done", 32'(done), 32'd1);
    check("halt reg_out", 32'(reg_out), 32'd80);
    check("halt cycle_count", cycle_count, 32'd12);
    tick(3);
    check("halt frozen count", cycle_count, 32'd12);

    // restart from HALT, condition 01 with z=0 falls through
    z_flag = 1'b0;
    pulse_start;
    check("restart reg_out", 32'(reg_out), 32'd1);
    check("restart done", 32'(done), 32'd0);
    check("restart cycle_count", cycle_count, 32'd0);
    tick(5);
    check("cond z=0 reg_out", 32'(reg_out), 32'd61);
    tick(1);
    check("halt61 done", 32'(done), 32'd1);

    // condition 11 with mem_ready already high: no stall
    rom[8]    = {1'b0, 2'b11, 7'd70};
    mem_ready = 1'b1;
    z_flag    = 1'b1;
    pulse_start;
    tick(4);
    check("nostall reg_out", 32'(reg_out), 32'd70);
    check("nostall cycle_count", cycle_count, 32'd4);
    tick(1);
    mem_ready = 1'b0;

    // dispatch to last legal word, then increment overflows to 86
    opcode  = 8'h55;
    rom[85] = {1'b0, 2'b10, 7'd0};
    pulse_start;
    tick(3);
    check("edge dispatch reg_out", 32'(reg_out), 32'd85);
    tick(1);
    check("overflow error", 32'(error), 32'd1);
    check("overflow reg_out", 32'(reg_out), 32'd0);
    do_reset;

    // opcode[7] set faults even though low bits are legal
    opcode = 8'h88;
    pulse_start;
    tick(3);
    check("op bit7 error", 32'(error), 32'd1);
    do_reset;

    // out-of-range jump taken on leaving WAIT
    opcode = 8'h08;
    rom[8] = {1'b0, 2'b11, 7'd100};
    pulse_start;
    tick(4);
    check("wait busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    check("wait fault error", 32'(error), 32'd1);
    do_reset;

    // dispatch 0x60 faults; start is ignored; only rst clears
    opcode = 8'h60;
    pulse_start;
    tick(3);
    check("op60 error", 32'(error), 32'd1);
    pulse_start;
    tick(2);
    check("fault sticky error", 32'(error), 32'd1);
    check("fault sticky reg_out", 32'(reg_out), 32'd0);
    rst = 1'b1;
    tick(1);
    check("fault cleared", 32'(error), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
